// File: rtl/riscv_pkg.sv
// Shared encodings for the RISC-V core: result-source select, ALU codes,
// register-address width and the EX-stage control bundle with its bubble value.
package riscv_pkg;

  localparam int REG_AW = 5;

  localparam logic [1:0] RESULT_SRC_ALU  = 2'b00;
  localparam logic [1:0] RESULT_SRC_LOAD = 2'b01;
  localparam logic [1:0] RESULT_SRC_PC4  = 2'b10;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SHL = 3'b110;
  localparam logic [2:0] ALU_SHR = 3'b111;

  typedef struct packed {
    logic       valid;
    logic       reg_write;
    logic       mem_write;
    logic [1:0] result_src;
    logic [2:0] alu_ctrl;
    logic       op7b5;
    logic       alu_src;
  } ex_ctrl_t;

  localparam ex_ctrl_t BUBBLE_CTRL = '{
    valid:      1'b0,
    reg_write:  1'b0,
    mem_write:  1'b0,
    result_src: RESULT_SRC_ALU,
    alu_ctrl:   ALU_ADD,
    op7b5:      1'b0,
    alu_src:    1'b0
  };

endpackage

// File: rtl/id_ex_stage_fwd_sel.sv
// Priority forward mux for one EX source operand: MEM beats WB, x0 never forwards.
module fwd_sel #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = 5
) (
  input  logic [REG_AW-1:0] src,
  input  logic [WIDTH-1:0]  reg_val,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_reg_write,
  input  logic [WIDTH-1:0]  m_val,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              w_reg_write,
  input  logic [WIDTH-1:0]  w_val,
  output logic [WIDTH-1:0]  val
);

  logic m_hit;
  logic w_hit;

  assign m_hit = m_reg_write && (m_rd != {REG_AW{1'b0}}) && (m_rd == src);
  assign w_hit = w_reg_write && (w_rd != {REG_AW{1'b0}}) && (w_rd == src);

  always_comb begin
    val = reg_val;
    if (m_hit) begin
      val = m_val;
    end else if (w_hit) begin
      val = w_val;
    end else begin
      val = reg_val;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with hazard stall and operand forwarding.
// Define ID_EX_FWD_EN to build the forwarding muxes; otherwise any RAW match stalls.
module id_ex_stage #(
  parameter int WIDTH  = 32,
  parameter int REG_AW = riscv_pkg::REG_AW
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              d_valid,
  input  logic [REG_AW-1:0] d_rs1,
  input  logic [REG_AW-1:0] d_rs2,
  input  logic [REG_AW-1:0] d_rd,
  input  logic [WIDTH-1:0]  d_rd1,
  input  logic [WIDTH-1:0]  d_rd2,
  input  logic [WIDTH-1:0]  d_imm,
  input  logic [WIDTH-1:0]  d_pc,
  input  logic [2:0]        d_alu_ctrl,
  input  logic              d_op7b5,
  input  logic              d_alu_src,
  input  logic              d_reg_write,
  input  logic              d_mem_write,
  input  logic [1:0]        d_result_src,
  input  logic              flush_e,
  input  logic [REG_AW-1:0] m_rd,
  input  logic              m_reg_write,
  input  logic [WIDTH-1:0]  m_alu_result,
  input  logic [REG_AW-1:0] w_rd,
  input  logic              w_reg_write,
  input  logic [WIDTH-1:0]  w_result,
  output logic              stall_d,
  output logic              e_valid,
  output logic [WIDTH-1:0]  e_a,
  output logic [WIDTH-1:0]  e_b,
  output logic [2:0]        e_alu_ctrl,
  output logic              e_op7b5,
  output logic [WIDTH-1:0]  e_write_data,
  output logic [REG_AW-1:0] e_rd,
  output logic              e_reg_write,
  output logic              e_mem_write,
  output logic [1:0]        e_result_src,
  output logic [WIDTH-1:0]  e_pc
);

  import riscv_pkg::*;

  ex_ctrl_t          ctrl;
  ex_ctrl_t          d_ctrl;
  logic [REG_AW-1:0] ex_rs1;
  logic [REG_AW-1:0] ex_rs2;
  logic [WIDTH-1:0]  ex_rd1;
  logic [WIDTH-1:0]  ex_rd2;
  logic [WIDTH-1:0]  ex_imm;
  logic [WIDTH-1:0]  src_a;
  logic [WIDTH-1:0]  src_b;
  logic              ex_match;

  assign d_ctrl = '{
    valid:      d_valid,
    reg_write:  d_reg_write,
    mem_write:  d_mem_write,
    result_src: d_result_src,
    alu_ctrl:   d_alu_ctrl,
    op7b5:      d_op7b5,
    alu_src:    d_alu_src
  };

  assign ex_match = ctrl.valid && ctrl.reg_write && (e_rd != {REG_AW{1'b0}}) &&
                    ((e_rd == d_rs1) || (e_rd == d_rs2));

`ifdef ID_EX_FWD_EN
  // With forwarding only a load in EX cannot be bypassed in time.
  assign stall_d = d_valid && ex_match && (ctrl.result_src == RESULT_SRC_LOAD);

  fwd_sel #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_a (
    .src(ex_rs1), .reg_val(ex_rd1),
    .m_rd(m_rd), .m_reg_write(m_reg_write), .m_val(m_alu_result),
    .w_rd(w_rd), .w_reg_write(w_reg_write), .w_val(w_result),
    .val(src_a)
  );

  fwd_sel #(.WIDTH(WIDTH), .REG_AW(REG_AW)) u_fwd_b (
    .src(ex_rs2), .reg_val(ex_rd2),
    .m_rd(m_rd), .m_reg_write(m_reg_write), .m_val(m_alu_result),
    .w_rd(w_rd), .w_reg_write(w_reg_write), .w_val(w_result),
    .val(src_b)
  );
`else
  logic m_match;
  logic unused_fwd;

  // Without bypass paths, hold decode until the producer has left MEM.
  assign m_match = m_reg_write && (m_rd != {REG_AW{1'b0}}) &&
                   ((m_rd == d_rs1) || (m_rd == d_rs2));
  assign stall_d = d_valid && (ex_match || m_match);

  assign src_a      = ex_rd1;
  assign src_b      = ex_rd2;
  assign unused_fwd = ^{ex_rs1, ex_rs2, m_alu_result, w_rd, w_reg_write, w_result};
`endif

  // EX pipeline register: bubble on flush or stall, otherwise capture decode.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ctrl   <= BUBBLE_CTRL;
      ex_rs1 <= {REG_AW{1'b0}};
      ex_rs2 <= {REG_AW{1'b0}};
      e_rd   <= {REG_AW{1'b0}};
      ex_rd1 <= {WIDTH{1'b0}};
      ex_rd2 <= {WIDTH{1'b0}};
      ex_imm <= {WIDTH{1'b0}};
      e_pc   <= {WIDTH{1'b0}};
    end else if (flush_e || stall_d) begin
      ctrl   <= BUBBLE_CTRL;
      ex_rs1 <= {REG_AW{1'b0}};
      ex_rs2 <= {REG_AW{1'b0}};
      e_rd   <= {REG_AW{1'b0}};
      ex_rd1 <= {WIDTH{1'b0}};
      ex_rd2 <= {WIDTH{1'b0}};
      ex_imm <= {WIDTH{1'b0}};
      e_pc   <= {WIDTH{1'b0}};
    end else begin
      ctrl   <= d_ctrl;
      ex_rs1 <= d_rs1;
      ex_rs2 <= d_rs2;
      e_rd   <= d_rd;
      ex_rd1 <= d_rd1;
      ex_rd2 <= d_rd2;
      ex_imm <= d_imm;
      e_pc   <= d_pc;
    end
  end

  assign e_valid      = ctrl.valid;
  assign e_reg_write  = ctrl.reg_write;
  assign e_mem_write  = ctrl.mem_write;
  assign e_result_src = ctrl.result_src;
  assign e_alu_ctrl   = ctrl.alu_ctrl;
  assign e_op7b5      = ctrl.op7b5;
  assign e_a          = src_a;
  assign e_b          = ctrl.alu_src ? ex_imm : src_b;
  assign e_write_data = src_b;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage; expectations follow ID_EX_FWD_EN when defined.
module tb_id_ex_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        d_valid;
  logic [4:0]  d_rs1, d_rs2, d_rd;
  logic [31:0] d_rd1, d_rd2, d_imm, d_pc;
  logic [2:0]  d_alu_ctrl;
  logic        d_op7b5, d_alu_src, d_reg_write, d_mem_write;
  logic [1:0]  d_result_src;
  logic        flush_e;
  logic [4:0]  m_rd, w_rd;
  logic        m_reg_write, w_reg_write;
  logic [31:0] m_alu_result, w_result;
  logic        stall_d, e_valid, e_op7b5, e_reg_write, e_mem_write;
  logic [31:0] e_a, e_b, e_write_data, e_pc;
  logic [2:0]  e_alu_ctrl;
  logic [4:0]  e_rd;
  logic [1:0]  e_result_src;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.WIDTH(32), .REG_AW(5)) dut (
    .clk(clk), .reset(reset), .d_valid(d_valid),
    .d_rs1(d_rs1), .d_rs2(d_rs2), .d_rd(d_rd), .d_rd1(d_rd1), .d_rd2(d_rd2),
    .d_imm(d_imm), .d_pc(d_pc), .d_alu_ctrl(d_alu_ctrl), .d_op7b5(d_op7b5),
    .d_alu_src(d_alu_src), .d_reg_write(d_reg_write), .d_mem_write(d_mem_write),
    .d_result_src(d_result_src), .flush_e(flush_e),
    .m_rd(m_rd), .m_reg_write(m_reg_write), .m_alu_result(m_alu_result),
    .w_rd(w_rd), .w_reg_write(w_reg_write), .w_result(w_result),
    .stall_d(stall_d), .e_valid(e_valid), .e_a(e_a), .e_b(e_b),
    .e_alu_ctrl(e_alu_ctrl), .e_op7b5(e_op7b5), .e_write_data(e_write_data),
    .e_rd(e_rd), .e_reg_write(e_reg_write), .e_mem_write(e_mem_write),
    .e_result_src(e_result_src), .e_pc(e_pc)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    d_valid = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_rd = 5'd0;
    d_rd1 = 32'd0; d_rd2 = 32'd0; d_imm = 32'd0; d_pc = 32'd0;
    d_alu_ctrl = 3'b000; d_op7b5 = 1'b0; d_alu_src = 1'b0;
    d_reg_write = 1'b0; d_mem_write = 1'b0; d_result_src = 2'b00;
    flush_e = 1'b0;
    m_rd = 5'd0; m_reg_write = 1'b0; m_alu_result = 32'd0;
    w_rd = 5'd0; w_reg_write = 1'b0; w_result = 32'd0;
  endtask

  task automatic idle_decode();
    d_valid = 1'b0; d_rs1 = 5'd0; d_rs2 = 5'd0; d_rd = 5'd0;
    d_rd1 = 32'd0; d_rd2 = 32'd0; d_imm = 32'd0; d_pc = 32'd0;
    d_alu_ctrl = 3'b000; d_op7b5 = 1'b0; d_alu_src = 1'b0;
    d_reg_write = 1'b0; d_mem_write = 1'b0; d_result_src = 2'b00;
  endtask

  task automatic drive_dec(input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                           input logic [31:0] rd1, input logic [31:0] rd2,
                           input logic [31:0] imm, input logic [31:0] pc,
                           input logic [2:0] alu, input logic op, input logic src,
                           input logic rw, input logic mw, input logic [1:0] rsrc);
    d_valid = 1'b1; d_rs1 = rs1; d_rs2 = rs2; d_rd = rd;
    d_rd1 = rd1; d_rd2 = rd2; d_imm = imm; d_pc = pc;
    d_alu_ctrl = alu; d_op7b5 = op; d_alu_src = src;
    d_reg_write = rw; d_mem_write = mw; d_result_src = rsrc;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    idle_inputs();
    #8;
    checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", e_valid); end
    checks++; if ({e_reg_write, e_mem_write} !== 2'b00) begin errors++; $display("FAIL rst_ctrl: got %b want 00", {e_reg_write, e_mem_write}); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL rst_stall: got %0b want 0", stall_d); end
    checks++; if ({e_a, e_b, e_write_data, e_pc, e_rd, e_alu_ctrl, e_result_src, e_op7b5} !== 139'd0) begin
      errors++; $display("FAIL rst_data: got a=%h b=%h wd=%h pc=%h want all 0", e_a, e_b, e_write_data, e_pc); end
    #4 reset = 1'b0;
    step();
    // lw x5 in EX, add x6,x5,x4 in decode, then reset mid-cycle
    drive_dec(5'd1, 5'd0, 5'd5, 32'h40, 32'h0, 32'h4, 32'h20, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    step();
    drive_dec(5'd5, 5'd4, 5'd6, 32'd11, 32'd22, 32'd0, 32'h24, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL rst_pre_stall: got %0b want 1", stall_d); end
    #2 reset = 1'b1;
    #1;
    checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL rst_mid_valid: got %0b want 0", e_valid); end
    checks++; if (e_reg_write !== 1'b0) begin errors++; $display("FAIL rst_mid_rw: got %0b want 0", e_reg_write); end
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL rst_mid_stall: got %0b want 0", stall_d); end
    checks++; if (e_pc !== 32'h0) begin errors++; $display("FAIL rst_mid_pc: got %h want 0", e_pc); end
    idle_inputs();
    step();
    reset = 1'b0;
  endtask

  task automatic test_back_to_back();
    idle_inputs();
    drive_dec(5'd1, 5'd2, 5'd7, 32'h11, 32'h22, 32'h33, 32'h100, 3'b101, 1'b1, 1'b1, 1'b1, 1'b0, 2'b10);
    step();
    checks++; if (e_valid !== 1'b1) begin errors++; $display("FAIL b2b_a_valid: got %0b want 1", e_valid); end
    checks++; if (e_pc !== 32'h100) begin errors++; $display("FAIL b2b_a_pc: got %h want 100", e_pc); end
    checks++; if ({e_alu_ctrl, e_op7b5, e_result_src} !== 6'b101_1_10) begin errors++; $display("FAIL b2b_a_ctrl: got %b want 101110", {e_alu_ctrl, e_op7b5, e_result_src}); end
    checks++; if (e_rd !== 5'd7) begin errors++; $display("FAIL b2b_a_rd: got %0d want 7", e_rd); end
    checks++; if ({e_a, e_b} !== {32'h11, 32'h33}) begin errors++; $display("FAIL b2b_a_ops: got a=%h b=%h want a=11 b=33", e_a, e_b); end
    checks++; if (e_write_data !== 32'h22) begin errors++; $display("FAIL b2b_a_wd: got %h want 22", e_write_data); end
    drive_dec(5'd3, 5'd4, 5'd8, 32'h44, 32'h55, 32'h66, 32'h104, 3'b010, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL b2b_no_stall: got %0b want 0", stall_d); end
    step();
    checks++; if (e_pc !== 32'h104) begin errors++; $display("FAIL b2b_b_pc: got %h want 104", e_pc); end
    checks++; if ({e_alu_ctrl, e_op7b5, e_result_src} !== 6'b010_0_00) begin errors++; $display("FAIL b2b_b_ctrl: got %b want 010000", {e_alu_ctrl, e_op7b5, e_result_src}); end
    checks++; if ({e_a, e_b} !== {32'h44, 32'h55}) begin errors++; $display("FAIL b2b_b_ops: got a=%h b=%h want a=44 b=55", e_a, e_b); end
    idle_decode();
    step();
    checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL b2b_idle_valid: got %0b want 0", e_valid); end
  endtask

  task automatic test_mem_forward();
    logic [31:0] exp_a;
    idle_inputs();
    drive_dec(5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 32'd0, 32'h200, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    step();
    idle_decode();
    m_rd = 5'd1; m_reg_write = 1'b1; m_alu_result = 32'd100;
    #1;
`ifdef ID_EX_FWD_EN
    exp_a = 32'd100;
`else
    exp_a = 32'd5;
`endif
    checks++; if (e_a !== exp_a) begin errors++; $display("FAIL fwd_mem_a: got %0d want %0d", e_a, exp_a); end
    checks++; if (e_b !== 32'd7) begin errors++; $display("FAIL fwd_mem_b: got %0d want 7", e_b); end
    w_rd = 5'd1; w_reg_write = 1'b1; w_result = 32'd50;
    #1;
    checks++; if (e_a !== exp_a) begin errors++; $display("FAIL fwd_mem_prio: got %0d want %0d", e_a, exp_a); end
    m_reg_write = 1'b0;
    #1;
`ifdef ID_EX_FWD_EN
    exp_a = 32'd50;
`else
    exp_a = 32'd5;
`endif
    checks++; if (e_a !== exp_a) begin errors++; $display("FAIL fwd_wb_a: got %0d want %0d", e_a, exp_a); end
    w_rd = 5'd2;
    #1;
`ifdef ID_EX_FWD_EN
    exp_a = 32'd50;
`else
    exp_a = 32'd7;
`endif
    checks++; if ({e_b, e_write_data} !== {exp_a, exp_a}) begin errors++; $display("FAIL fwd_wb_b: got b=%0d wd=%0d want %0d", e_b, e_write_data, exp_a); end
    checks++; if (e_a !== 32'd5) begin errors++; $display("FAIL fwd_wb_a_reg: got %0d want 5", e_a); end
    idle_inputs();
  endtask

  task automatic test_x0_guard();
    idle_inputs();
    drive_dec(5'd0, 5'd0, 5'd9, 32'd0, 32'd0, 32'd0, 32'h240, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    step();
    idle_decode();
    m_rd = 5'd0; m_reg_write = 1'b1; m_alu_result = 32'hFFFF;
    w_rd = 5'd0; w_reg_write = 1'b1; w_result = 32'h1234;
    #1;
    checks++; if (e_a !== 32'd0) begin errors++; $display("FAIL x0_a: got %h want 0", e_a); end
    checks++; if (e_b !== 32'd0) begin errors++; $display("FAIL x0_b: got %h want 0", e_b); end
    idle_inputs();
  endtask

  task automatic test_load_use();
    idle_inputs();
    step();
    drive_dec(5'd1, 5'd0, 5'd5, 32'h40, 32'h0, 32'h4, 32'h300, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    step();
    drive_dec(5'd5, 5'd4, 5'd6, 32'd11, 32'd22, 32'd0, 32'h304, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 2'b00);
    #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_stall: got %0b want 1", stall_d); end
    step();
    m_rd = 5'd5; m_reg_write = 1'b1; m_alu_result = 32'h44;
    checks++; if ({e_valid, e_reg_write} !== 2'b00) begin errors++; $display("FAIL lu_bubble: got %b want 00", {e_valid, e_reg_write}); end
    #1;
`ifdef ID_EX_FWD_EN
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_one_cycle: got %0b want 0", stall_d); end
    step();
    m_reg_write = 1'b0; w_rd = 5'd5; w_reg_write = 1'b1; w_result = 32'd77;
    #1;
    checks++; if ({e_valid, e_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu_enter: got %b want 100110", {e_valid, e_rd}); end
    checks++; if ({e_a, e_b} !== {32'd77, 32'd22}) begin errors++; $display("FAIL lu_ops: got a=%0d b=%0d want a=77 b=22", e_a, e_b); end
`else
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL lu_mem_stall: got %0b want 1", stall_d); end
    step();
    checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL lu_bubble2: got %0b want 0", e_valid); end
    m_reg_write = 1'b0; w_rd = 5'd5; w_reg_write = 1'b1; w_result = 32'd77;
    #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL lu_release: got %0b want 0", stall_d); end
    step();
    checks++; if ({e_valid, e_rd} !== {1'b1, 5'd6}) begin errors++; $display("FAIL lu_enter: got %b want 100110", {e_valid, e_rd}); end
    checks++; if ({e_a, e_b} !== {32'd11, 32'd22}) begin errors++; $display("FAIL lu_ops: got a=%0d b=%0d want a=11 b=22", e_a, e_b); end
`endif
    idle_inputs();
    step();
  endtask

  task automatic test_flush();
    idle_inputs();
    step();
    drive_dec(5'd1, 5'd2, 5'd0, 32'h10, 32'h20, 32'h8, 32'h400, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    flush_e = 1'b1;
    #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL fl_no_stall: got %0b want 0", stall_d); end
    step();
    checks++; if ({e_valid, e_mem_write} !== 2'b00) begin errors++; $display("FAIL fl_bubble: got %b want 00", {e_valid, e_mem_write}); end
    checks++; if (e_pc !== 32'h0) begin errors++; $display("FAIL fl_pc: got %h want 0", e_pc); end
    flush_e = 1'b0;
    drive_dec(5'd1, 5'd0, 5'd5, 32'h40, 32'h0, 32'h4, 32'h408, 3'b000, 1'b0, 1'b1, 1'b1, 1'b0, 2'b01);
    step();
    drive_dec(5'd5, 5'd3, 5'd7, 32'h1, 32'h2, 32'h0, 32'h40c, 3'b000, 1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
    flush_e = 1'b1;
    #1;
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL fl_stall_held: got %0b want 1", stall_d); end
    step();
    checks++; if ({e_valid, e_mem_write, e_reg_write} !== 3'b000) begin errors++; $display("FAIL fl_prio: got %b want 000", {e_valid, e_mem_write, e_reg_write}); end
    idle_inputs();
  endtask

  task automatic test_store_data();
    idle_inputs();
    step();
    drive_dec(5'd1, 5'd2, 5'd0, 32'h1000, 32'h11, 32'd8, 32'h500, 3'b000, 1'b0, 1'b1, 1'b0, 1'b1, 2'b00);
    m_rd = 5'd2; m_reg_write = 1'b1; m_alu_result = 32'hAB;
    #1;
`ifdef ID_EX_FWD_EN
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL st_no_stall: got %0b want 0", stall_d); end
    step();
    idle_decode();
    #1;
    checks++; if (e_b !== 32'd8) begin errors++; $display("FAIL st_b: got %h want 8", e_b); end
    checks++; if (e_write_data !== 32'hAB) begin errors++; $display("FAIL st_wd: got %h want ab", e_write_data); end
    checks++; if ({e_a, e_mem_write} !== {32'h1000, 1'b1}) begin errors++; $display("FAIL st_a_mw: got a=%h mw=%0b want a=1000 mw=1", e_a, e_mem_write); end
`else
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL st_stall: got %0b want 1", stall_d); end
    step();
    checks++; if (e_valid !== 1'b0) begin errors++; $display("FAIL st_bubble: got %0b want 0", e_valid); end
    checks++; if (stall_d !== 1'b1) begin errors++; $display("FAIL st_stall_persist: got %0b want 1", stall_d); end
    m_reg_write = 1'b0;
    #1;
    checks++; if (stall_d !== 1'b0) begin errors++; $display("FAIL st_release: got %0b want 0", stall_d); end
    step();
    idle_decode();
    #1;
    checks++; if (e_b !== 32'd8) begin errors++; $display("FAIL st_b: got %h want 8", e_b); end
    checks++; if (e_write_data !== 32'h11) begin errors++; $display("FAIL st_wd: got %h want 11", e_write_data); end
    checks++; if ({e_valid, e_mem_write} !== 2'b11) begin errors++; $display("FAIL st_valid_mw: got %b want 11", {e_valid, e_mem_write}); end
`endif
    idle_inputs();
    step();
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_mem_forward();
    test_x0_guard();
    test_load_use();
    test_flush();
    test_store_data();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_ex_stage.md
Name: id_ex_stage

Overview:
- ID/EX pipeline register and operand-select stage that sits directly upstream of the ALU.
- Captures decoded instruction fields at the end of decode and resolves RAW hazards, by forwarding from MEM/WB or by stalling.
- Drives the ALU operands `a`/`b`, `alu_ctrl` and `op7b5`, plus the store data and control that travel on to MEM.
- Also inserts bubbles on load-use stalls and on branch flushes.

Parameters:
- WIDTH, 32, datapath width of operands, immediates and PC.
- REG_AW, 5, register-address width.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- d_valid  in  1  decode stage holds a real instruction.
- d_rs1, d_rs2, d_rd  in  REG_AW  source/destination register addresses.
- d_rd1, d_rd2  in  WIDTH  register-file read data.
- d_imm  in  WIDTH  sign-extended immediate.
- d_pc  in  WIDTH  instruction PC.
- d_alu_ctrl  in  3  ALU operation code.
- d_op7b5  in  1  funct7 bit 5 (SRA/SRL select).
- d_alu_src  in  1  1 = ALU b operand is the immediate.
- d_reg_write, d_mem_write  in  1  control bits.
- d_result_src  in  2  00 ALU, 01 load, 10 PC+4.
- flush_e  in  1  squash the instruction entering EX (branch taken).
- m_rd  in  REG_AW  MEM-stage destination register.
- m_reg_write  in  1  MEM-stage write enable.
- m_alu_result  in  WIDTH  MEM-stage ALU result.
- w_rd  in  REG_AW  WB-stage destination register.
- w_reg_write  in  1  WB-stage write enable.
- w_result  in  WIDTH  WB-stage result.
- stall_d  out  1  hold fetch/decode this cycle.
- e_valid  out  1  EX holds a real instruction.
- e_a, e_b  out  WIDTH  ALU operands.
- e_alu_ctrl  out  3  ALU operation code.
- e_op7b5  out  1  funct7 bit 5.
- e_write_data  out  WIDTH  forwarded rs2 value, used as store data.
- e_rd  out  REG_AW  EX destination register.
- e_reg_write, e_mem_write  out  1  EX control bits.
- e_result_src  out  2  EX result source.
- e_pc  out  WIDTH  EX PC.

Behaviour:
- Reset: one clock `clk`; reset `reset` is asynchronous and active-high. It clears every EX register to zero, so immediately after reset `e_valid=0`, `e_reg_write=0`, `e_mem_write=0`, all data outputs are 0 and `stall_d=0`.
- Latency: one cycle. Fields present on `d_*` at rising edge N appear on `e_*` after edge N.
- Bubble: `valid`, `reg_write` and `mem_write` are 0, `result_src=00`, `alu_ctrl=000`, data fields hold 0.
- Load at the EX register on each edge, in priority order:
  - `flush_e` set: load a bubble.
  - `stall_d` set: load a bubble.
  - otherwise: load the `d_*` fields, with `valid = d_valid`.
- Load-use hazard: `stall_d` = `d_valid` AND `e_valid` AND `e_reg_write` AND `e_result_src==01` AND `e_rd!=0` AND (`e_rd==d_rs1` OR `e_rd==d_rs2`). It is combinational and lasts exactly one cycle per load.
- Forwarding, applied separately to registered rs1 and rs2 (combinational on the outputs):
  - If `m_reg_write`, `m_rd!=0` and `m_rd` equals the source register, use `m_alu_result`.
  - Else if the same holds for the W stage, use `w_result`.
  - Else use the registered `rd1`/`rd2`.
  - MEM has priority over WB; `x0` is never forwarded.
- Operand outputs:
  - `e_a` = forwarded rs1.
  - `e_b` = `e_imm` if `alu_src`, else forwarded rs2.
  - `e_write_data` = forwarded rs2 in all cases.
- Register-file timing: the register file writes on the falling edge, so an instruction in WB while its consumer is in decode needs no hazard handling here.
- Reset mid-stall: the EX register clears immediately, `stall_d` drops the same cycle, and no partial instruction survives.
- `flush_e` and `stall_d` in the same cycle: the EX register loads a bubble. `stall_d` is still asserted so decode holds, and upstream flush logic owns decode.

Optional Feature:
- Macro: ID_EX_FWD_EN.
- Defined: forwarding operates as described above; `stall_d` covers the load-use case only.
- Undefined:
  - No forwarding muxes are built; `e_a`/`e_b`/`e_write_data` come from the registered values only.
  - `stall_d` asserts for any RAW match, with `rd!=0`, against a valid writing instruction in EX (`e_rd`/`e_reg_write`) or in MEM (`m_rd`/`m_reg_write`).
  - The stall persists until no such match remains.

Decomposition:
- Shared package `riscv_pkg` holds:
  - `RESULT_SRC_ALU`, `RESULT_SRC_LOAD`, `RESULT_SRC_PC4` encodings.
  - The `ALU_ADD`..`ALU_SHR` 3-bit codes.
  - The `REG_AW` constant.
  - The bubble control constant.
- One sub-module: `fwd_sel`, a 3-input priority forward mux instantiated twice, for rs1 and rs2.

Test Plan:
- Reset: assert `reset` asynchronously mid-cycle with a valid instruction in EX -> all `e_*` are 0 and `stall_d=0` before the next edge.
- MEM forward:
  - Decode `add x3,x1,x2` with `rd1=5`, `rd2=7`.
  - Next cycle drive `m_rd=1`, `m_reg_write=1`, `m_alu_result=100`.
  - Expect `e_a=100`, `e_b=7`.
  - Also drive `w_rd=1` with `w_result=50` -> `e_a` still 100.
- x0 guard: `m_rd=0`, `m_reg_write=1`, `m_alu_result=0xFFFF`, EX sources `rs1=0`, `rd1=0` -> `e_a=0`.
- Load-use:
  - `lw x5` in EX, decode `add x6,x5,x4` with `d_valid=1` -> `stall_d=1` for one cycle.
  - The next EX is a bubble (`e_valid=0`, `e_reg_write=0`).
  - The cycle after, the add enters with `e_valid=1`.
- Flush priority: `flush_e=1` together with a load-use stall -> EX bubble, `e_mem_write=0`, `e_reg_write=0`.
- Store data: `sw x2,8(x1)` with `alu_src=1`, `imm=8`, `m_rd=2`, `m_alu_result=0xAB` -> `e_b=8`, `e_write_data=0xAB`. Without `ID_EX_FWD_EN`, the same setup -> `stall_d=1` until MEM clears.
